// File: rtl/cube_net_renderer_if.sv
// Pixel write bus between the cube net renderer (master) and a pixel sink
// such as vga_adapter (slave). A pixel is transferred on a rising clock edge
// where plot and plot_ready are both high.
interface cube_net_renderer_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CD = 3
);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CD-1:0] colour;
  logic          plot;
  logic          plot_ready;

  modport master (output x, output y, output colour, output plot, input plot_ready);
  modport slave  (input x, input y, input colour, input plot, output plot_ready);
endinterface

// File: rtl/cube_net_renderer.sv
// cube_net_renderer
// Draws an NxN cube as a cross-shaped net into a pixel write stream.
// Face order 0..5 = front, back, left, right, top, bottom. Face state is
// snapshotted at the start of every pass so a frame never mixes old and new
// moves. Back-pressure via plot_ready; one redraw request can queue while busy.
// Optional feature: define CUBE_RENDER_CLEAR_EN to wipe the net bounding box
// with BG_COLOUR before each pass draws the stickers.
module cube_net_renderer #(
  parameter int N                   = 3,
  parameter int CELL                = 4,
  parameter int CD                  = 3,
  parameter int XW                  = 8,
  parameter int YW                  = 7,
  parameter int ORIGIN_X            = 8,
  parameter int ORIGIN_Y            = 4,
  parameter logic [CD-1:0] BG_COLOUR = {CD{1'b0}}
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [6*N*N*CD-1:0]   faces,
  input  logic                  start,
  cube_net_renderer_if.master   pix,
  output logic                  busy,
  output logic                  done
);

  localparam int F   = N * CELL;
  localparam int FW  = 6 * N * N * CD;
  localparam int SIW = $clog2(FW);
  localparam logic [2:0] RC_MAX   = 3'(N - 1);
  localparam logic [2:0] P_MAX    = 3'(CELL - 1);
  localparam logic [2:0] FACE_MAX = 3'd5;

  if (ORIGIN_X + 4 * F - 1 >= (1 << XW)) begin : g_bad_x
    $error("cube_net_renderer: net does not fit in XW bits");
  end
  if (ORIGIN_Y + 3 * F - 1 >= (1 << YW)) begin : g_bad_y
    $error("cube_net_renderer: net does not fit in YW bits");
  end
  if (N < 2 || N > 7 || CELL < 3 || CELL > 8 || $bits(BG_COLOUR) != CD) begin : g_bad_cfg
    $error("cube_net_renderer: unsupported N/CELL/BG_COLOUR configuration");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_DRAW  = 2'd2,
    S_FIN   = 2'd3
  } state_t;

`ifdef CUBE_RENDER_CLEAR_EN
  localparam state_t S_FIRST = S_CLEAR;
`else
  localparam state_t S_FIRST = S_DRAW;
`endif

  // Net tile column of each face, in units of F.
  function automatic logic [1:0] tile_fx(input logic [2:0] face);
    case (face)
      3'd0:    tile_fx = 2'd1;
      3'd1:    tile_fx = 2'd3;
      3'd2:    tile_fx = 2'd0;
      3'd3:    tile_fx = 2'd2;
      3'd4:    tile_fx = 2'd1;
      3'd5:    tile_fx = 2'd1;
      default: tile_fx = 2'd0;
    endcase
  endfunction

  // Net tile row of each face, in units of F.
  function automatic logic [1:0] tile_fy(input logic [2:0] face);
    case (face)
      3'd4:    tile_fy = 2'd0;
      3'd5:    tile_fy = 2'd2;
      default: tile_fy = 2'd1;
    endcase
  endfunction

  state_t        r_state, w_state_nxt;
  logic [FW-1:0] r_snap;
  logic          r_pending, w_pending_nxt;
  logic          w_pass_start, w_adv_draw, w_xfer, w_draw_last;

  // Draw counters always describe the pixel currently presented on the bus.
  logic [2:0] r_face, r_row, r_col, r_py, r_px;
  logic [2:0] w_i_face, w_i_row, w_i_col, w_i_py, w_i_px;
  logic [2:0] w_n_face, w_n_row, w_n_col, w_n_py, w_n_px;

  logic [XW-1:0]  r_x, w_dx;
  logic [YW-1:0]  r_y, w_dy;
  logic [CD-1:0]  r_colour, w_dcol;
  logic [FW-1:0]  w_src;
  logic [SIW-1:0] w_sbase;
  logic           r_plot, r_busy, r_done;

`ifdef CUBE_RENDER_CLEAR_EN
  localparam logic [7:0] CX_MAX = 8'(4 * F - 1);
  localparam logic [7:0] CY_MAX = 8'(3 * F - 1);
  logic [7:0]    r_cx, r_cy, w_n_cx, w_n_cy;
  logic          w_adv_clear, w_clear_last;
  logic [XW-1:0] w_cxp;
  logic [YW-1:0] w_cyp;

  // Next clear-raster position: restart per pass, x inner, y outer.
  always_comb begin
    w_clear_last = (r_cx == CX_MAX) && (r_cy == CY_MAX);
    w_n_cx = r_cx;
    w_n_cy = r_cy;
    if (w_pass_start) begin
      w_n_cx = 8'd0;
      w_n_cy = 8'd0;
    end else if (w_adv_clear) begin
      if (r_cx == CX_MAX) begin
        w_n_cx = 8'd0;
        w_n_cy = r_cy + 8'd1;
      end else begin
        w_n_cx = r_cx + 8'd1;
      end
    end else begin
      w_n_cx = r_cx;
    end
    w_cxp = XW'(ORIGIN_X + int'(w_n_cx));
    w_cyp = YW'(ORIGIN_Y + int'(w_n_cy));
  end

  // Clear-raster position register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cx <= 8'd0;
      r_cy <= 8'd0;
    end else begin
      r_cx <= w_n_cx;
      r_cy <= w_n_cy;
    end
  end
`endif

  assign w_xfer = r_plot & pix.plot_ready;

  // Nested draw-counter increment: face, row, col, py, px (px fastest).
  always_comb begin
    w_i_face = r_face;
    w_i_row  = r_row;
    w_i_col  = r_col;
    w_i_py   = r_py;
    w_i_px   = r_px + 3'd1;
    if (r_px == P_MAX) begin
      w_i_px = 3'd0;
      w_i_py = r_py + 3'd1;
      if (r_py == P_MAX) begin
        w_i_py  = 3'd0;
        w_i_col = r_col + 3'd1;
        if (r_col == RC_MAX) begin
          w_i_col = 3'd0;
          w_i_row = r_row + 3'd1;
          if (r_row == RC_MAX) begin
            w_i_row  = 3'd0;
            w_i_face = r_face + 3'd1;
          end else begin
            w_i_face = r_face;
          end
        end else begin
          w_i_row = r_row;
        end
      end else begin
        w_i_col = r_col;
      end
    end else begin
      w_i_py = r_py;
    end
    w_draw_last = (r_face == FACE_MAX) && (r_row == RC_MAX) && (r_col == RC_MAX) &&
                  (r_py == P_MAX) && (r_px == P_MAX);
  end

  // FSM next state, pass start, counter advance and redraw queueing.
  always_comb begin
    w_state_nxt   = r_state;
    w_pass_start  = 1'b0;
    w_adv_draw    = 1'b0;
    w_pending_nxt = r_pending;
`ifdef CUBE_RENDER_CLEAR_EN
    w_adv_clear   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pass_start = 1'b1;
          w_state_nxt  = S_FIRST;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
`ifdef CUBE_RENDER_CLEAR_EN
      S_CLEAR: begin
        if (start) w_pending_nxt = 1'b1;
        else       w_pending_nxt = r_pending;
        if (w_xfer) begin
          if (w_clear_last) w_state_nxt = S_DRAW;
          else              w_adv_clear = 1'b1;
        end else begin
          w_state_nxt = S_CLEAR;
        end
      end
`endif
      S_DRAW: begin
        if (start) w_pending_nxt = 1'b1;
        else       w_pending_nxt = r_pending;
        if (w_xfer) begin
          if (w_draw_last) w_state_nxt = S_FIN;
          else             w_adv_draw  = 1'b1;
        end else begin
          w_state_nxt = S_DRAW;
        end
      end
      S_FIN: begin
        // A request arriving in this very cycle is treated like a queued one.
        if (r_pending || start) begin
          w_pass_start = 1'b1;
          w_state_nxt  = S_FIRST;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pixel that will be presented after this edge: address, position and colour.
  always_comb begin
    if (w_pass_start) begin
      w_n_face = 3'd0;
      w_n_row  = 3'd0;
      w_n_col  = 3'd0;
      w_n_py   = 3'd0;
      w_n_px   = 3'd0;
      w_src    = faces;
    end else if (w_adv_draw) begin
      w_n_face = w_i_face;
      w_n_row  = w_i_row;
      w_n_col  = w_i_col;
      w_n_py   = w_i_py;
      w_n_px   = w_i_px;
      w_src    = r_snap;
    end else begin
      w_n_face = r_face;
      w_n_row  = r_row;
      w_n_col  = r_col;
      w_n_py   = r_py;
      w_n_px   = r_px;
      w_src    = r_snap;
    end
    w_dx = XW'(ORIGIN_X + int'(tile_fx(w_n_face)) * F + int'(w_n_col) * CELL + int'(w_n_px));
    w_dy = YW'(ORIGIN_Y + int'(tile_fy(w_n_face)) * F + int'(w_n_row) * CELL + int'(w_n_py));
    w_sbase = SIW'((int'(w_n_face) * N * N + int'(w_n_row) * N + int'(w_n_col)) * CD);
    if (w_n_px == P_MAX || w_n_py == P_MAX) w_dcol = {CD{1'b0}};
    else                                    w_dcol = w_src[w_sbase +: CD];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Snapshot, counters and registered bus/status outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_snap    <= {FW{1'b0}};
      r_pending <= 1'b0;
      r_face    <= 3'd0;
      r_row     <= 3'd0;
      r_col     <= 3'd0;
      r_py      <= 3'd0;
      r_px      <= 3'd0;
      r_x       <= {XW{1'b0}};
      r_y       <= {YW{1'b0}};
      r_colour  <= {CD{1'b0}};
      r_plot    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_pass_start) r_snap <= faces;
      else              r_snap <= r_snap;
      r_pending <= w_pass_start ? 1'b0 : w_pending_nxt;
      r_face    <= w_n_face;
      r_row     <= w_n_row;
      r_col     <= w_n_col;
      r_py      <= w_n_py;
      r_px      <= w_n_px;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_done    <= (w_state_nxt == S_FIN);
      r_plot    <= (w_state_nxt == S_DRAW) || (w_state_nxt == S_CLEAR);
      if (w_state_nxt == S_DRAW) begin
        r_x      <= w_dx;
        r_y      <= w_dy;
        r_colour <= w_dcol;
      end
`ifdef CUBE_RENDER_CLEAR_EN
      else if (w_state_nxt == S_CLEAR) begin
        r_x      <= w_cxp;
        r_y      <= w_cyp;
        r_colour <= BG_COLOUR;
      end
`endif
      else begin
        r_x      <= r_x;
        r_y      <= r_y;
        r_colour <= r_colour;
      end
    end
  end

  assign pix.x      = r_x;
  assign pix.y      = r_y;
  assign pix.colour = r_colour;
  assign pix.plot   = r_plot;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_cube_net_renderer.sv
// Self-checking bench for cube_net_renderer (N=3, CELL=4). Expected pixels
// come from a closed-form model: pixel index k is decomposed with division
// and modulo into face/row/col/py/px and mapped through the net layout.
`timescale 1ns/1ps
module tb_cube_net_renderer;
  localparam int N = 3, CELL = 4, CD = 3, XW = 8, YW = 7, OX = 8, OY = 4;
  localparam logic [CD-1:0] BG = 3'd0;
  localparam int F = N * CELL;
  localparam int FW = 6 * N * N * CD;
  localparam int NET_PIX = 6 * N * N * CELL * CELL;
`ifdef CUBE_RENDER_CLEAR_EN
  localparam int CLR_PIX = 12 * F * F;
`else
  localparam int CLR_PIX = 0;
`endif
  localparam int TOTAL = CLR_PIX + NET_PIX;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CD-1:0] c;
  } pix_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [FW-1:0] faces = '0;
  logic          busy, done;
  int            checks = 0;
  int            errors = 0;

  cube_net_renderer_if #(.XW(XW), .YW(YW), .CD(CD)) pif ();

  cube_net_renderer #(
    .N(N), .CELL(CELL), .CD(CD), .XW(XW), .YW(YW),
    .ORIGIN_X(OX), .ORIGIN_Y(OY), .BG_COLOUR(BG)
  ) dut (
    .clk(clk), .resetn(resetn), .faces(faces), .start(start),
    .pix(pif), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: k-th pixel of a pass for a given face snapshot.
  function automatic pix_t ref_pix(input logic [FW-1:0] f, input int k);
    int   kk, face, row, col, py, px;
    int   tfx[6];
    int   tfy[6];
    pix_t p;
    tfx = '{1, 3, 0, 2, 1, 1};
    tfy = '{1, 1, 1, 1, 0, 2};
    kk = k;
    if (kk < CLR_PIX) begin
      p.x = XW'(OX + kk % (4 * F));
      p.y = YW'(OY + kk / (4 * F));
      p.c = BG;
      return p;
    end
    kk   = kk - CLR_PIX;
    px   = kk % CELL;
    py   = (kk / CELL) % CELL;
    col  = (kk / (CELL * CELL)) % N;
    row  = (kk / (CELL * CELL * N)) % N;
    face = kk / (CELL * CELL * N * N);
    p.x  = XW'(OX + tfx[face] * F + col * CELL + px);
    p.y  = YW'(OY + tfy[face] * F + row * CELL + py);
    if (px == CELL - 1 || py == CELL - 1) p.c = 3'd0;
    else p.c = f[(face * N * N + row * N + col) * CD +: CD];
    return p;
  endfunction

  // Bus monitor: records transfers, done pulses, stall stability, busy gaps.
  pix_t xq[$];
  int   done_cnt = 0, stall_viol = 0, busy_low = 0, done_bad = 0;
  bit   track_busy = 1'b0;
  int   busy_target = 0;
  logic prev_stall = 1'b0;
  pix_t prev_pix = '0;
  always @(negedge clk) begin
    pix_t cur;
    cur = {pif.x, pif.y, pif.colour};
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!pif.plot || cur != prev_pix)) stall_viol++;
      prev_stall = pif.plot && !pif.plot_ready;
      prev_pix   = cur;
      if (pif.plot && pif.plot_ready) xq.push_back(cur);
      if (done) begin
        done_cnt++;
        if (pif.plot || !busy) done_bad++;
      end
      if (track_busy && done_cnt < busy_target && !busy) busy_low++;
    end
  end

  // Sink readiness: always ready, or toggling every cycle in stall mode.
  bit stall_mode = 1'b0;
  initial begin
    pif.plot_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_mode) pif.plot_ready = ~pif.plot_ready;
      else            pif.plot_ready = 1'b1;
    end
  end

  task automatic rand_faces(output logic [FW-1:0] f);
    for (int i = 0; i < FW; i++) f[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic mon_clear();
    xq.delete();
    done_cnt = 0; stall_viol = 0; busy_low = 0; done_bad = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({pif.x, pif.y, pif.colour, pif.plot} !== '0) begin
      errors++; $display("FAIL reset_bus got %0h want 0", {pif.x, pif.y, pif.colour, pif.plot});
    end
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_status got %b want 00", {busy, done});
    end
    @(posedge clk); #1 resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({pif.plot, busy, done} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset got %b want 000", {pif.plot, busy, done});
    end
  endtask

  task automatic test_single_pass();
    logic [FW-1:0] f;
    bit ok;
    int bad;
    rand_faces(f);
    faces = f;
    mon_clear();
    pulse_start();
    @(negedge clk);
    checks++;
    if ({pif.plot, busy} !== 2'b11) begin
      errors++; $display("FAIL first_plot got %b want 11", {pif.plot, busy});
    end
    checks++;
    if ({pif.x, pif.y, pif.colour} !== ref_pix(f, 0)) begin
      errors++; $display("FAIL first_pixel got %0h want %0h", {pif.x, pif.y, pif.colour}, ref_pix(f, 0));
    end
    wait_done(1, TOTAL + 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done_timeout got 0 want 1"); end
    repeat (3) @(negedge clk);
    checks++;
    if (xq.size() !== TOTAL) begin
      errors++; $display("FAIL single_count got %0d want %0d", xq.size(), TOTAL);
    end
    bad = 0;
    for (int k = 0; k < xq.size() && k < TOTAL; k++) begin
      checks++;
      if (xq[k] !== ref_pix(f, k)) begin
        errors++;
        if (bad < 4) $display("FAIL single_pixel[%0d] got %0h want %0h", k, xq[k], ref_pix(f, k));
        bad++;
      end
    end
    checks++;
    if (done_cnt !== 1 || done_bad !== 0) begin
      errors++; $display("FAIL single_done got cnt=%0d bad=%0d want cnt=1 bad=0", done_cnt, done_bad);
    end
    checks++;
    if ({busy, done, pif.plot} !== 3'b000) begin
      errors++; $display("FAIL single_idle got %b want 000", {busy, done, pif.plot});
    end
  endtask

  task automatic test_stall();
    logic [FW-1:0] f;
    bit ok;
    int bad;
    rand_faces(f);
    faces = f;
    mon_clear();
    stall_mode = 1'b1;
    pulse_start();
    wait_done(1, 2 * TOTAL + 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_done_timeout got 0 want 1"); end
    repeat (3) @(negedge clk);
    stall_mode = 1'b0;
    checks++;
    if (xq.size() !== TOTAL) begin
      errors++; $display("FAIL stall_count got %0d want %0d", xq.size(), TOTAL);
    end
    checks++;
    if (stall_viol !== 0) begin
      errors++; $display("FAIL stall_stable got %0d changes want 0", stall_viol);
    end
    bad = 0;
    for (int k = 0; k < xq.size() && k < TOTAL; k++) begin
      checks++;
      if (xq[k] !== ref_pix(f, k)) begin
        errors++;
        if (bad < 4) $display("FAIL stall_pixel[%0d] got %0h want %0h", k, xq[k], ref_pix(f, k));
        bad++;
      end
    end
  endtask

  task automatic test_snapshot();
    logic [FW-1:0] f1, f2;
    bit ok;
    int bad;
    rand_faces(f1);
    f2 = ~f1;
    faces = f1;
    mon_clear();
    pulse_start();
    repeat (10) @(posedge clk);
    #1 faces = f2;
    wait_done(1, TOTAL + 50, ok);
    checks++;
    if (!ok || xq.size() !== TOTAL) begin
      errors++; $display("FAIL snap_old_count got %0d want %0d", xq.size(), TOTAL);
    end
    bad = 0;
    for (int k = 0; k < xq.size() && k < TOTAL; k++) begin
      checks++;
      if (xq[k] !== ref_pix(f1, k)) begin
        errors++;
        if (bad < 4) $display("FAIL snap_old[%0d] got %0h want %0h", k, xq[k], ref_pix(f1, k));
        bad++;
      end
    end
    repeat (3) @(negedge clk);
    mon_clear();
    pulse_start();
    wait_done(1, TOTAL + 50, ok);
    checks++;
    if (!ok || xq.size() !== TOTAL) begin
      errors++; $display("FAIL snap_new_count got %0d want %0d", xq.size(), TOTAL);
    end
    bad = 0;
    for (int k = 0; k < xq.size() && k < TOTAL; k++) begin
      checks++;
      if (xq[k] !== ref_pix(f2, k)) begin
        errors++;
        if (bad < 4) $display("FAIL snap_new[%0d] got %0h want %0h", k, xq[k], ref_pix(f2, k));
        bad++;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] f;
    bit ok;
    int bad;
    rand_faces(f);
    faces = f;
    mon_clear();
    busy_target = 2;
    pulse_start();
    track_busy = 1'b1;
    repeat (100) @(posedge clk);
    pulse_start();
    repeat (50) @(posedge clk);
    pulse_start();
    wait_done(2, 3 * TOTAL, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_done_timeout got %0d want 2", done_cnt); end
    repeat (20) @(negedge clk);
    track_busy = 1'b0;
    checks++;
    if (done_cnt !== 2 || done_bad !== 0) begin
      errors++; $display("FAIL b2b_done got cnt=%0d bad=%0d want cnt=2 bad=0", done_cnt, done_bad);
    end
    checks++;
    if (busy_low !== 0) begin
      errors++; $display("FAIL b2b_busy_gap got %0d want 0", busy_low);
    end
    checks++;
    if (xq.size() !== 2 * TOTAL || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_count got %0d busy=%b want %0d busy=0", xq.size(), busy, 2 * TOTAL);
    end
    bad = 0;
    for (int k = 0; k < xq.size() && k < 2 * TOTAL; k++) begin
      checks++;
      if (xq[k] !== ref_pix(f, k % TOTAL)) begin
        errors++;
        if (bad < 4) $display("FAIL b2b_pixel[%0d] got %0h want %0h", k, xq[k], ref_pix(f, k % TOTAL));
        bad++;
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    logic [FW-1:0] f;
    bit ok;
    int bad;
    rand_faces(f);
    faces = f;
    mon_clear();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < TOTAL + 50; i++) begin
      @(negedge clk);
      if (xq.size() >= 300) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_reach300 got %0d want 300", xq.size()); end
    resetn = 1'b0;
    #1;
    checks++;
    if ({pif.x, pif.y, pif.colour, pif.plot, busy, done} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got %0h want 0", {pif.x, pif.y, pif.colour, pif.plot, busy, done});
    end
    @(posedge clk); #1 resetn = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0 || pif.plot !== 1'b0) begin
      errors++; $display("FAIL rst_abandon got done=%0d busy=%b plot=%b want 0 0 0", done_cnt, busy, pif.plot);
    end
    rand_faces(f);
    faces = f;
    mon_clear();
    pulse_start();
    wait_done(1, TOTAL + 50, ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!ok || xq.size() !== TOTAL) begin
      errors++; $display("FAIL rst_new_pass got %0d want %0d", xq.size(), TOTAL);
    end
    bad = 0;
    for (int k = 0; k < xq.size() && k < TOTAL; k++) begin
      checks++;
      if (xq[k] !== ref_pix(f, k)) begin
        errors++;
        if (bad < 4) $display("FAIL rst_pixel[%0d] got %0h want %0h", k, xq[k], ref_pix(f, k));
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_stall();
    test_snapshot();
    test_back_to_back();
    test_reset_mid_pass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
